// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, constants and fetch-sequencer encodings for the byte-serial
// instruction fetch controller.
package if_fetch_ctrl_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;

   localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } fetch_state_t;

   typedef enum logic {
      P_REQ  = 1'b0,
      P_WAIT = 1'b1
   } fetch_phase_t;

endpackage

// File: rtl/if_fetch_ctrl_inst_byte_asm.sv
// Four-lane byte register that gathers a little-endian instruction word. The lane
// being written this cycle is forwarded so the completed word is visible at once.
module if_fetch_ctrl_inst_byte_asm
   import if_fetch_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                clear,
   input  logic                we,
   input  logic [1:0]          lane,
   input  logic [7:0]          din,
   output logic [INST_BUS-1:0] word
);

   logic [7:0] lanes [4];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < 4; i++) begin
            lanes[i] <= '0;
         end
      end else if (we) begin
         lanes[lane] <= din;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         word[8*i +: 8] = (we && lane == 2'(i)) ? din : lanes[i];
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// PC generator and byte-serial fetcher: pulls four bytes over the shared 8-bit
// memory port, assembles a little-endian word and presents it to the IF stage.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = INST_ADDR_BUS,
   parameter int                INST_W   = INST_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              br_flag_i,
   input  logic [ADDR_W-1:0] br_target_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [7:0]        mem_rdata_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              inst_valid_o
);

   fetch_state_t      state;
   fetch_phase_t      phase;
   logic [ADDR_W-1:0] fetch_pc;
   logic [1:0]        idx;
   logic              pend;
   logic              drop;
   logic [ADDR_W-1:0] target_al;
   logic              still_out;
   logic              byte_take;
   logic [INST_W-1:0] asm_word;

   assign target_al = br_target_i & ~ADDR_W'(3);

   // A byte is still in flight after this cycle if one was pending (ours or stale)
   // and did not return now, or if a grant is being given right now.
   assign still_out = ((pend || drop) && !mem_rvalid_i) || (mem_req_o && mem_gnt_i);
   assign byte_take = !br_flag_i && state == S_FETCH && phase == P_WAIT && pend && mem_rvalid_i;

   if_fetch_ctrl_inst_byte_asm u_asm (
      .clk   (clk),
      .clear (rst || br_flag_i),
      .we    (byte_take),
      .lane  (idx),
      .din   (mem_rdata_i),
      .word  (asm_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_FETCH;
         phase        <= P_REQ;
         fetch_pc     <= RESET_PC;
         idx          <= '0;
         pend         <= 1'b0;
         drop         <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= RESET_PC;
         pc_o         <= '0;
         inst_o       <= ZERO_WORD;
         inst_valid_o <= 1'b0;
      end else if (br_flag_i) begin
         state        <= S_FETCH;
         phase        <= P_REQ;
         fetch_pc     <= target_al;
         idx          <= '0;
         pend         <= 1'b0;
         drop         <= still_out;
         mem_req_o    <= !still_out;
         mem_addr_o   <= target_al;
         inst_valid_o <= 1'b0;
      end else if (state == S_FETCH) begin
         // A stale byte from before a redirect must drain before we ask again.
         if (drop) begin
            if (mem_rvalid_i) begin
               drop      <= 1'b0;
               mem_req_o <= 1'b1;
            end
         end else if (phase == P_REQ) begin
            if (mem_req_o && mem_gnt_i) begin
               pend      <= 1'b1;
               phase     <= P_WAIT;
               mem_req_o <= 1'b0;
            end else begin
               mem_req_o <= 1'b1;
            end
         end else if (byte_take) begin
            pend <= 1'b0;
            if (idx == 2'd3) begin
               inst_o       <= asm_word;
               pc_o         <= fetch_pc;
               inst_valid_o <= 1'b1;
               state        <= S_HOLD;
            end else begin
               idx        <= idx + 2'd1;
               phase      <= P_REQ;
               mem_req_o  <= 1'b1;
               mem_addr_o <= fetch_pc + ADDR_W'(idx + 2'd1);
            end
         end
      end else if (!stall_i) begin
         inst_valid_o <= 1'b0;
         fetch_pc     <= fetch_pc + ADDR_W'(4);
         idx          <= '0;
         state        <= S_FETCH;
         phase        <= P_REQ;
         mem_req_o    <= 1'b1;
         mem_addr_o   <= fetch_pc + ADDR_W'(4);
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomised self-checking bench: two instances (RESET_PC 0 and 0xFFFFFFFC) share all
// inputs and are each compared every cycle against a transaction-level model.
module tb_if_fetch_ctrl;

   localparam logic [31:0] PC0 = 32'h0000_0000;
   localparam logic [31:0] PC1 = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        br_flag_i;
   logic [31:0] br_target_i;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [7:0]  mem_rdata_i;

   logic        req0, req1, valid0, valid1;
   logic [31:0] addr0, addr1, pc0, pc1, inst0, inst1;

   always #5 clk = ~clk;

   if_fetch_ctrl #(.RESET_PC(PC0)) dut0 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .br_flag_i(br_flag_i),
      .br_target_i(br_target_i), .mem_req_o(req0), .mem_addr_o(addr0),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .pc_o(pc0), .inst_o(inst0), .inst_valid_o(valid0)
   );

   if_fetch_ctrl #(.RESET_PC(PC1)) dut1 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .br_flag_i(br_flag_i),
      .br_target_i(br_target_i), .mem_req_o(req1), .mem_addr_o(addr1),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .pc_o(pc1), .inst_o(inst1), .inst_valid_o(valid1)
   );

   // Model view: which word is being gathered, how many bytes are in, and whether a
   // byte of ours or a stale one is on its way back.
   typedef struct {
      logic [31:0] base;
      int          nbytes;
      logic [31:0] word;
      bit          in_flight;
      bit          stale;
      bit          have;
      bit          req;
      logic [31:0] out_pc;
      logic [31:0] out_inst;
   } model_t;

   model_t m0, m1;

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;
   bit armed = 0;

   int gntPct = 100, rvMin = 1, rvMax = 1, stallPct = 0, brPct = 0, spurPct = 0, rstPermille = 0;
   bit forceStall = 0, forceBr = 0, forceRst = 0;
   logic [31:0] forceTgt = '0;

   bit          memBusy = 0;
   int          memDelay = 0;
   logic [7:0]  memData = '0;
   logic [31:0] grantAddrs[$];

   function automatic model_t modelReset(logic [31:0] rpc);
      model_t m;
      m.base = rpc; m.nbytes = 0; m.word = '0;
      m.in_flight = 0; m.stale = 0; m.have = 0; m.req = 0;
      m.out_pc = '0; m.out_inst = '0;
      return m;
   endfunction

   function automatic model_t modelStep(model_t m, bit gnt, bit rv, logic [7:0] rd,
                                        bit stall, bit br, logic [31:0] tgt);
      model_t n = m;
      bit granted = m.req && gnt;
      if (br) begin
         n.stale     = ((m.in_flight || m.stale) && !rv) || granted;
         n.in_flight = 0;
         n.base      = tgt & 32'hFFFF_FFFC;
         n.nbytes    = 0;
         n.have      = 0;
      end else begin
         if (m.stale) begin
            if (rv) n.stale = 0;
         end else if (granted) begin
            n.in_flight = 1;
         end else if (m.in_flight && rv) begin
            n.in_flight = 0;
            n.word      = {rd, m.word[31:8]};
            n.nbytes    = m.nbytes + 1;
            if (n.nbytes == 4) begin
               n.have     = 1;
               n.out_inst = n.word;
               n.out_pc   = m.base;
            end
         end
         if (m.have && !stall) begin
            n.have   = 0;
            n.base   = m.base + 32'd4;
            n.nbytes = 0;
         end
      end
      n.req = !n.have && !n.in_flight && !n.stale;
      return n;
   endfunction

   function automatic logic [7:0] memByte(logic [31:0] a);
      if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
      return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'hA5;
   endfunction

   task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(string name);
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: got no event within the cycle budget, expected one (cycle %0d)", name, cyc);
   endtask

   task automatic checkOutput();
      if (!armed) return;
      checkValue("valid0", 32'(valid0), 32'(m0.have));
      checkValue("req0",   32'(req0),   32'(m0.req));
      checkValue("pc0",    pc0,   m0.out_pc);
      checkValue("inst0",  inst0, m0.out_inst);
      if (m0.req) checkValue("addr0", addr0, m0.base + 32'(m0.nbytes));
      checkValue("valid1", 32'(valid1), 32'(m1.have));
      checkValue("req1",   32'(req1),   32'(m1.req));
      checkValue("pc1",    pc1,   m1.out_pc);
      checkValue("inst1",  inst1, m1.out_inst);
      if (m1.req) checkValue("addr1", addr1, m1.base + 32'(m1.nbytes));
   endtask

   // Acts as the shared memory and drives control inputs, then advances both models.
   task automatic applyStimulus();
      bit          g, rv, st, b, r;
      logic [7:0]  rd;
      logic [31:0] t;
      r  = forceRst || ($urandom_range(999, 0) < rstPermille);
      rv = 0;
      rd = 8'($urandom);
      if (memBusy) begin
         if (memDelay == 0) begin
            rv = 1;
            rd = memData;
            memBusy = 0;
         end else begin
            memDelay--;
         end
      end else if ($urandom_range(99, 0) < spurPct) begin
         rv = 1;
      end
      g = (req0 === 1'b1) && ($urandom_range(99, 0) < gntPct);
      if (g) begin
         memBusy  = 1;
         memDelay = int'($urandom_range(rvMax, rvMin)) - 1;
         memData  = memByte(addr0);
         grantAddrs.push_back(addr0);
      end
      st = forceStall || ($urandom_range(99, 0) < stallPct);
      b  = forceBr || ($urandom_range(99, 0) < brPct);
      t  = forceBr ? forceTgt : $urandom;
      if (r) memBusy = 0;
      rst          = r;
      mem_gnt_i    = g;
      mem_rvalid_i = rv;
      mem_rdata_i  = rd;
      stall_i      = st;
      br_flag_i    = b;
      br_target_i  = t;
      if (r) begin
         m0 = modelReset(PC0);
         m1 = modelReset(PC1);
         armed = 1;
      end else begin
         m0 = modelStep(m0, g, rv, rd, st, b, t);
         m1 = modelStep(m1, g, rv, rd, st, b, t);
      end
   endtask

   task automatic runCycle();
      @(negedge clk);
      cyc++;
      checkOutput();
      applyStimulus();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish by time limit, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  t0, t1;
      bit  hit;
      rst = 1'b1; stall_i = 1'b0; br_flag_i = 1'b0; br_target_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      forceRst = 1;
      runCycle();
      runCycle();
      forceRst = 0;
      checkValue("rst_req",   32'(req0), 32'd0);
      checkValue("rst_valid", 32'(valid0), 32'd0);
      checkValue("rst_pc",    pc0, 32'd0);
      checkValue("rst_inst",  inst0, 32'd0);
      checkValue("rst_addr0", addr0, PC0);
      checkValue("rst_addr1", addr1, PC1);

      // First word from address 0 with immediate grants and one-cycle read latency.
      grantAddrs.delete();
      forceStall = 1;
      t0 = -1; t1 = -1;
      for (int i = 0; i < 40 && t1 < 0; i++) begin
         runCycle();
         if (req0 === 1'b1 && t0 < 0) t0 = cyc;
         if (valid0 === 1'b1) t1 = cyc;
      end
      if (t1 < 0 || grantAddrs.size() < 4) begin
         timeout("first_word");
      end else begin
         for (int i = 0; i < 4; i++) checkValue("first_addrs", grantAddrs[i], 32'(i));
         checkValue("first_inst", inst0, 32'h0000_0013);
         checkValue("first_pc0",  pc0, 32'h0000_0000);
         checkValue("first_pc1",  pc1, 32'hFFFF_FFFC);
         checkValue("first_latency", 32'(t1 - t0), 32'd8);
      end

      // Stall held for five cycles while the word is valid.
      for (int i = 0; i < 4; i++) begin
         runCycle();
         checkValue("stall_valid", 32'(valid0), 32'd1);
         checkValue("stall_req",   32'(req0), 32'd0);
         checkValue("stall_inst",  inst0, 32'h0000_0013);
      end
      forceStall = 0;
      runCycle();
      runCycle();
      checkValue("post_stall_req",   32'(req0), 32'd1);
      checkValue("post_stall_addr0", addr0, 32'h0000_0004);
      checkValue("wrap_addr1",       addr1, 32'h0000_0000);

      // Redirect while byte 1 is outstanding; the stale byte must drain first.
      rvMin = 3; rvMax = 3;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         if (m0.in_flight && m0.nbytes == 1 && memBusy && memDelay > 0) hit = 1;
         else runCycle();
      end
      if (!hit) timeout("redirect_setup");
      forceBr = 1; forceTgt = 32'h0000_0102;
      runCycle();
      forceBr = 0;
      grantAddrs.delete();
      runCycle();
      checkValue("drop_req", 32'(req0), 32'd0);
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         runCycle();
         if (valid0 === 1'b1) hit = 1;
      end
      if (!hit || grantAddrs.size() == 0) begin
         timeout("redirect_word");
      end else begin
         checkValue("redirect_addr", grantAddrs[0], 32'h0000_0100);
         checkValue("redirect_pc",   pc0, 32'h0000_0100);
      end

      // Redirect coinciding with the byte-3 return, then grants withheld three cycles.
      rvMin = 1; rvMax = 1;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         if (m0.in_flight && m0.nbytes == 3 && memBusy && memDelay == 0) hit = 1;
         else runCycle();
      end
      if (!hit) timeout("late_redirect_setup");
      forceBr = 1; forceTgt = 32'h0000_0200; gntPct = 0;
      runCycle();
      forceBr = 0;
      for (int i = 0; i < 3; i++) begin
         runCycle();
         checkValue("late_valid", 32'(valid0), 32'd0);
         checkValue("hold_req",   32'(req0), 32'd1);
         checkValue("hold_addr",  addr0, 32'h0000_0200);
      end
      gntPct = 100;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         runCycle();
         if (valid0 === 1'b1) hit = 1;
      end
      if (!hit) begin
         timeout("withheld_word");
      end else begin
         checkValue("withheld_inst", inst0, 32'h9485_B6A7);
         checkValue("withheld_pc",   pc0, 32'h0000_0200);
      end

      // Reset while a byte is outstanding.
      rvMin = 3; rvMax = 3;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         if (m0.in_flight && memBusy && memDelay > 0) hit = 1;
         else runCycle();
      end
      if (!hit) timeout("midwait_setup");
      forceRst = 1;
      runCycle();
      forceRst = 0;
      runCycle();
      checkValue("midrst_req",   32'(req0), 32'd0);
      checkValue("midrst_valid", 32'(valid0), 32'd0);
      checkValue("midrst_pc",    pc0, 32'd0);
      checkValue("midrst_inst",  inst0, 32'd0);
      checkValue("midrst_addr0", addr0, PC0);
      checkValue("midrst_addr1", addr1, PC1);

      // Long randomised run with back-pressure, redirects, spurious returns and resets.
      gntPct = 60; rvMin = 1; rvMax = 3; stallPct = 35; brPct = 4; spurPct = 5; rstPermille = 2;
      for (int i = 0; i < 3000; i++) runCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
